// File: rtl/sin_lut_512points.sv
// sin_lut_512points: registered full-period sine from a quarter-wave table with quadrant folding
module sin_lut_512points #(
    parameter int DW   = 18,
    parameter int AW   = 10,
    parameter int FRAC = 16
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] Dout
);
    localparam int N = 1 << (AW - 2);
    localparam logic [127:0] PI_Q60 = 128'h3243F6A8885A308D;

    // sin(pi*k/(2N)) scaled by 2**FRAC, rounded half away from zero; Taylor series in Q60
    function automatic logic [DW-1:0] quarter_sin(input int k);
        logic [127:0] x, x2, term, sum;
        x    = (PI_Q60 * 128'(k)) >> (AW - 1);
        x2   = (x * x) >> 60;
        term = x;
        sum  = x;
        for (int n = 1; n <= 14; n++) begin
            term = ((term * x2) >> 60) / 128'((2 * n) * (2 * n + 1));
            sum  = (n % 2 == 1) ? sum - term : sum + term;
        end
        return DW'(((sum << FRAC) + (128'd1 << 59)) >> 60);
    endfunction

    logic [DW-1:0] tbl [0:N];

    for (genvar g = 0; g <= N; g++) begin : g_tbl
        localparam logic [DW-1:0] V = quarter_sin(g);
        assign tbl[g] = V;
    end

    logic [1:0]    q;
    logic [AW-3:0] i;
    logic [AW-2:0] idx;
    logic [DW-1:0] mag, val;

    // fold the phase into the first quadrant, then restore the sign
    always_comb begin
        q   = addr[AW-1:AW-2];
        i   = addr[AW-3:0];
        idx = q[0] ? (AW-1)'(N) - {1'b0, i} : {1'b0, i};
        mag = tbl[idx];
        val = q[1] ? -mag : mag;
    end

    // single output register, cleared asynchronously
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) Dout <= '0;
        else       Dout <= val;
    end
endmodule

// File: tb/tb_sin_lut_512points.sv
// tb_sin_lut_512points: directed and sweep checks of the sine table against a real-valued model
module tb_sin_lut_512points;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  addr;
    logic [17:0] dout;
    logic [17:0] model_q;
    logic [17:0] res [0:1023];
    logic        chk_en = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    sin_lut_512points dut (.Clk(clk), .reset(reset), .addr(addr), .Dout(dout));

    always #10 clk = ~clk;

    function automatic real sin_real(input int k);
        return $sin(2.0 * 3.14159265358979323846 * k / 1024.0) * 65536.0;
    endfunction

    function automatic logic [17:0] sin_ref(input int k);
        real v;
        int  r;
        v = sin_real(k);
        r = (v >= 0.0) ? $rtoi($floor(v + 0.5)) : -$rtoi($floor(-v + 0.5));
        return 18'(r);
    endfunction

    task automatic check(input logic [17:0] got, input logic [17:0] exp, input string nm);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", nm, $signed(got), $signed(exp));
        end
    endtask

    task automatic apply(input int a, input logic [17:0] want, input string nm);
        addr = 10'(a);
        @(posedge clk);
        #1;
        check(dout, want, nm);
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_q <= '0;
        else       model_q <= sin_ref(int'(addr));
    end

    always @(negedge clk) begin
        if (chk_en) check(dout, model_q, "cycle_model");
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        real d;
        reset = 1'b1;
        addr  = '0;
        check(sin_ref(20), 18'd8022, "model_pin_20");
        check(sin_ref(128), 18'd46341, "model_pin_128");
        check(sin_ref(1023), 18'h3FE6E, "model_pin_1023");
        #1  check(dout, 18'd0, "reset_before_edge");
        #40 check(dout, 18'd0, "reset_mid");
        #58 check(dout, 18'd0, "reset_end");
        #1;
        addr   = 10'd20;
        reset  = 1'b0;
        chk_en = 1'b1;
        @(posedge clk);
        #1 check(dout, 18'd8022, "first_after_reset");
        apply(30, 18'd11996, "addr30");
        apply(70, 18'd27291, "addr70");
        apply(0, 18'd0, "q0");
        apply(256, 18'd65536, "q1");
        apply(512, 18'd0, "q2");
        apply(768, 18'h30000, "q3");
        apply(1023, 18'h3FE6E, "addr1023");
        for (int k = 0; k < 1024; k++) begin
            addr = 10'(k);
            @(posedge clk);
            #1;
            res[k] = dout;
            d = $itor($signed(dout)) - sin_real(k);
            n_tests++;
            if (d > 0.5 || d < -0.5) begin
                n_fail++;
                $display("FAIL sweep_err k=%0d got=%0d want=%f", k, $signed(dout), sin_real(k));
            end
        end
        for (int k = 1; k < 256; k++) check(res[k], res[512 - k], "sym_half");
        for (int k = 0; k < 512; k++) check(res[k + 512], -res[k], "sym_neg");
        apply(100, sin_ref(100), "stream100");
        apply(200, sin_ref(200), "stream200");
        addr = 10'd300;
        #4 reset = 1'b1;
        #1 check(dout, 18'd0, "midreset_now");
        #2 reset = 1'b0;
        #1 check(dout, 18'd0, "midreset_hold");
        @(posedge clk);
        #1 check(dout, sin_ref(300), "midreset_resume");
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
